// File: rtl/tmul_pkg.sv
// Shared constants, state encoding and array types for the tile sequencer.
package tmul_pkg;

  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int ACC_W = 2 * DW;
  localparam int IW    = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef logic [DW-1:0]              elem_t;
  typedef logic [N*DW-1:0]            brow_t;
  typedef logic [N-1:0][DW-1:0]       avec_t;
  typedef logic [N-1:0][N*DW-1:0]     bmat_t;
  typedef logic [N-1:0][ACC_W-1:0]    accvec_t;

endpackage

// File: rtl/tmul_tile_sequencer_if.sv
// Command, load, multiplier and result signals of the tile sequencer.
interface tmul_tile_sequencer_if;
  import tmul_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_ntiles;
  logic              ld_valid;
  logic              ld_ready;
  elem_t             ld_a;
  brow_t             ld_b;
  avec_t             tm_a;
  bmat_t             tm_b;
  accvec_t           tm_c;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [IW-1:0]     res_idx;
  logic              res_last;
  logic              busy;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_ntiles, ld_valid, ld_a, ld_b, tm_c, res_ready,
    output cmd_ready, ld_ready, tm_a, tm_b, res_valid, res_data, res_idx,
           res_last, busy
  );

  // DMA / datapath / consumer side
  modport master (
    output cmd_valid, cmd_ntiles, ld_valid, ld_a, ld_b, tm_c, res_ready,
    input  cmd_ready, ld_ready, tm_a, tm_b, res_valid, res_data, res_idx,
           res_last, busy
  );

endinterface

// File: rtl/tmul_acc_bank.sv
// Bank of N wide accumulators: either loads or adds the multiplier output
// when sampled, and exposes one entry selected by index.
module tmul_acc_bank
  import tmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             load_sel,
  input  accvec_t          tm_c,
  input  logic [IW-1:0]    rd_idx,
  output logic [ACC_W-1:0] rd_data
);

  accvec_t acc_q, acc_d;

  // Next accumulator values: overwrite on the first tile, wrap-add afterwards
  always_comb begin
    acc_d = acc_q;
    if (sample_en) begin
      for (int m = 0; m < N; m++) begin
        acc_d[m] = load_sel ? tm_c[m] : acc_q[m] + tm_c[m];
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign rd_data = acc_q[rd_idx];

endmodule

// File: rtl/tmul_tile_sequencer.sv
// Tile sequencer for the 8x8 32-bit multiplier: loads operand rows, holds
// them for the multiplier latency, accumulates across tiles, drains results.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a job command
// ST_LOAD  | accepting one A element + B row per beat into row registers
// ST_WAIT  | operands held; sample tm_c when the wait counter hits 1
// ST_DRAIN | streaming the eight accumulators out by index
module tmul_tile_sequencer
  import tmul_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tmul_tile_sequencer_if.slave  bus
);

  localparam int WCW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  state_e          state_q, state_d;
  logic [3:0]      tiles_left_q, tiles_left_d;
  logic [IW-1:0]   row_q, row_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            first_q, first_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  avec_t           tm_a_q, tm_a_d;
  bmat_t           tm_b_q, tm_b_d;
  logic            sample_en;

  assign sample_en = (state_q == ST_WAIT) && (wcnt_q == WCW'(1));

  // FSM next-state, counters and operand row writes
  always_comb begin
    state_d      = state_q;
    tiles_left_d = tiles_left_q;
    row_d        = row_q;
    idx_d        = idx_q;
    first_d      = first_q;
    wcnt_d       = wcnt_q;
    tm_a_d       = tm_a_q;
    tm_b_d       = tm_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          tiles_left_d = bus.cmd_ntiles;
          row_d        = '0;
          first_d      = 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.ld_valid) begin
          tm_a_d[row_q] = bus.ld_a;
          tm_b_d[row_q] = bus.ld_b;
          row_d         = row_q + 1'b1;
          if (row_q == IW'(N - 1)) begin
            row_d   = '0;
            wcnt_d  = WCW'(MUL_LAT);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == WCW'(1)) begin
          first_d = 1'b0;
          if (tiles_left_q != 4'd0) begin
            tiles_left_d = tiles_left_q - 1'b1;
            state_d      = ST_LOAD;
          end else begin
            idx_d   = '0;
            state_d = ST_DRAIN;
          end
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.res_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tiles_left_q <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      wcnt_q       <= '0;
      tm_a_q       <= '0;
      tm_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      tiles_left_q <= tiles_left_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      first_q      <= first_d;
      wcnt_q       <= wcnt_d;
      tm_a_q       <= tm_a_d;
      tm_b_q       <= tm_b_d;
    end
  end

  tmul_acc_bank u_acc (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .load_sel  (first_q),
    .tm_c      (bus.tm_c),
    .rd_idx    (idx_q),
    .rd_data   (bus.res_data)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.ld_ready  = (state_q == ST_LOAD);
  assign bus.res_valid = (state_q == ST_DRAIN);
  assign bus.res_last  = (state_q == ST_DRAIN) && (idx_q == IW'(N - 1));
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res_idx   = idx_q;
  assign bus.tm_a      = tm_a_q;
  assign bus.tm_b      = tm_b_q;

endmodule

// File: tb/tb_tmul_tile_sequencer.sv
// Directed bench for tmul_tile_sequencer: two instances (MUL_LAT 1 and 3)
// share one stimulus driver; a behavioral multiplier supplies tm_c.
module tb_tmul_tile_sequencer;
  import tmul_pkg::*;

  typedef struct {
    string       name;
    bit          lat3;
    logic [3:0]  ntiles;
    bit          ones;
    bit          gaps;
    bit          rr_toggle;
    int          exp_first;
    int          exp_beat9;
    logic [63:0] exp_base;
    logic [63:0] exp_step;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        cmd_valid;
  logic [3:0]  cmd_ntiles;
  logic        ld_valid;
  elem_t       ld_a;
  brow_t       ld_b;
  logic        res_ready;

  logic        o_cmd_ready, o_ld_ready, o_res_valid, o_res_last, o_busy;
  logic [63:0] o_res_data;
  logic [2:0]  o_res_idx;
  avec_t       o_tm_a;
  bmat_t       o_tm_b;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  tmul_tile_sequencer_if if1 ();
  tmul_tile_sequencer_if if3 ();

  function automatic accvec_t mul_model(input avec_t a, input bmat_t b);
    accvec_t c;
    for (int m = 0; m < N; m++) begin
      c[m] = '0;
      for (int j = 0; j < N; j++) begin
        c[m] = c[m] + 64'(a[j]) * 64'(b[j][m*DW +: DW]);
      end
    end
    return c;
  endfunction

  assign if1.cmd_valid  = cmd_valid & ~sel;
  assign if3.cmd_valid  = cmd_valid & sel;
  assign if1.ld_valid   = ld_valid & ~sel;
  assign if3.ld_valid   = ld_valid & sel;
  assign if1.cmd_ntiles = cmd_ntiles;
  assign if3.cmd_ntiles = cmd_ntiles;
  assign if1.ld_a       = ld_a;
  assign if3.ld_a       = ld_a;
  assign if1.ld_b       = ld_b;
  assign if3.ld_b       = ld_b;
  assign if1.res_ready  = res_ready;
  assign if3.res_ready  = res_ready;
  assign if1.tm_c       = mul_model(if1.tm_a, if1.tm_b);
  assign if3.tm_c       = mul_model(if3.tm_a, if3.tm_b);

  assign o_cmd_ready = sel ? if3.cmd_ready : if1.cmd_ready;
  assign o_ld_ready  = sel ? if3.ld_ready  : if1.ld_ready;
  assign o_res_valid = sel ? if3.res_valid : if1.res_valid;
  assign o_res_last  = sel ? if3.res_last  : if1.res_last;
  assign o_busy      = sel ? if3.busy      : if1.busy;
  assign o_res_data  = sel ? if3.res_data  : if1.res_data;
  assign o_res_idx   = sel ? if3.res_idx   : if1.res_idx;
  assign o_tm_a      = sel ? if3.tm_a      : if1.tm_a;
  assign o_tm_b      = sel ? if3.tm_b      : if1.tm_b;

  tmul_tile_sequencer #(.MUL_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  tmul_tile_sequencer #(.MUL_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input bit l3, input logic [3:0] nt,
                              input bit on, input bit gp, input bit rr, input int ef,
                              input int e9, input logic [63:0] base, input logic [63:0] step);
    vec_t v;
    v.name = nm; v.lat3 = l3; v.ntiles = nt; v.ones = on; v.gaps = gp;
    v.rr_toggle = rr; v.exp_first = ef; v.exp_beat9 = e9;
    v.exp_base = base; v.exp_step = step;
    return v;
  endfunction

  task automatic drive_data(input bit ones, input int row);
    ld_a = ones ? '1 : elem_t'(row + 1);
    for (int k = 0; k < N; k++) ld_b[k*DW +: DW] = ones ? '1 : DW'(k + 1);
  endtask

  task automatic run_job(input vec_t v);
    int n, beats, nres, first_n, beat9_n;
    bit prev_hold;
    logic [63:0] prev_data, exp;
    logic [2:0] prev_idx;
    logic prev_last;
    sel = v.lat3;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ntiles = v.ntiles; ld_valid = 1'b1; res_ready = 1'b1;
    drive_data(v.ones, 0);
    #1;
    check({v.name, ".cmd_ready_idle"}, 64'(o_cmd_ready), 64'd1);
    n = 0; beats = 0; nres = 0; first_n = -1; beat9_n = -1; prev_hold = 1'b0;
    prev_data = '0; prev_idx = '0; prev_last = 1'b0;
    while (nres < 8 && n < 2000) begin
      @(negedge clk);
      n++;
      cmd_valid  = (n == 3);
      cmd_ntiles = (n == 3) ? 4'hA : v.ntiles;
      ld_valid   = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      res_ready  = v.rr_toggle ? n[0] : 1'b1;
      drive_data(v.ones, beats % 8);
      #1;
      if (n == 3) check({v.name, ".cmd_blocked_busy"}, 64'(o_cmd_ready), 64'd0);
      if (prev_hold) begin
        check({v.name, ".hold_data"}, o_res_data, prev_data);
        check({v.name, ".hold_idx"}, 64'(o_res_idx), 64'(prev_idx));
        check({v.name, ".hold_last"}, 64'(o_res_last), 64'(prev_last));
      end
      if (ld_valid && o_ld_ready) begin
        beats++;
        if (beats == 9) beat9_n = n;
      end
      if (o_res_valid) begin
        if (first_n < 0) first_n = n;
        if (res_ready) begin
          exp = v.exp_base + 64'(nres) * v.exp_step;
          check({v.name, ".res_data"}, o_res_data, exp);
          check({v.name, ".res_idx"}, 64'(o_res_idx), 64'(nres));
          check({v.name, ".res_last"}, 64'(o_res_last), 64'(nres == 7));
          nres++;
        end
        prev_hold = !res_ready;
        prev_data = o_res_data; prev_idx = o_res_idx; prev_last = o_res_last;
      end else begin
        prev_hold = 1'b0;
      end
    end
    check({v.name, ".result_count"}, 64'(nres), 64'd8);
    if (v.exp_first >= 0) check({v.name, ".first_valid_cycle"}, 64'(first_n), 64'(v.exp_first));
    if (v.exp_beat9 >= 0) check({v.name, ".tile2_load_cycle"}, 64'(beat9_n), 64'(v.exp_beat9));
    @(negedge clk);
    cmd_valid = 1'b0; ld_valid = 1'b0; res_ready = 1'b1;
    #1;
    check({v.name, ".busy_after"}, 64'(o_busy), 64'd0);
    check({v.name, ".cmd_ready_after"}, 64'(o_cmd_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_ready"}, 64'(o_cmd_ready), 64'd1);
    check({tag, ".ld_ready"}, 64'(o_ld_ready), 64'd0);
    check({tag, ".res_valid"}, 64'(o_res_valid), 64'd0);
    check({tag, ".res_last"}, 64'(o_res_last), 64'd0);
    check({tag, ".busy"}, 64'(o_busy), 64'd0);
    check({tag, ".res_data"}, o_res_data, 64'd0);
    check({tag, ".res_idx"}, 64'(o_res_idx), 64'd0);
    check({tag, ".tm_a_zero"}, 64'(o_tm_a == '0), 64'd1);
    check({tag, ".tm_b_zero"}, 64'(o_tm_b == '0), 64'd1);
  endtask

  initial begin
    vecs[0] = mk("single_lat1",  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10,  -1, 64'd36, 64'd36);
    vecs[1] = mk("two_lat1",     1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 19,  10, 64'd72, 64'd72);
    vecs[2] = mk("single_lat3",  1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 12,  -1, 64'd36, 64'd36);
    vecs[3] = mk("two_lat3",     1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 23,  12, 64'd72, 64'd72);
    vecs[4] = mk("backpressure", 1'b0, 4'd1,  1'b0, 1'b1, 1'b1, -1,  -1, 64'd72, 64'd72);
    vecs[5] = mk("wrap_lat1",    1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 145, 10,
                 64'hFFFF_FF00_0000_0080, 64'd0);
    vecs[6] = mk("wrap_bp_lat3", 1'b1, 4'd15, 1'b1, 1'b1, 1'b1, -1,  -1,
                 64'hFFFF_FF00_0000_0080, 64'd0);

    sel = 1'b0; cmd_valid = 1'b0; cmd_ntiles = '0; ld_valid = 1'b0;
    ld_a = '0; ld_b = '0; res_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_lat1");
    sel = 1'b1; #1;
    check_reset_outputs("reset_lat3");
    sel = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Reset asserted mid-cycle while the MUL_LAT=1 instance is at LOAD row 4
    sel = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ntiles = 4'd0; ld_valid = 1'b1; drive_data(1'b0, 4);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("midjob.busy_before_reset", 64'(o_busy), 64'd1);
    check("midjob.acc_nonzero_before", 64'(o_res_data != 64'd0), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midjob_reset");
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b0;
    run_job(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
